// File: rtl/mips_dmem_responder_if.sv
// mips_dmem_responder_if: request/response channels between the load/store initiator and the data memory
interface mips_dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: word data memory for the MIPS load/store port with a fixed access latency
module mips_dmem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input logic                  clk,
   input logic                  reset,
   mips_dmem_responder_if.slave bus
);
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WL = 4'(WAIT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t        state;
   logic [3:0]    cnt;
   logic          l_write;
   logic [31:0]   l_addr, l_wdata;
   logic [3:0]    l_be;
   logic [31:0]   mem [DEPTH_WORDS];
   logic          acc, commit, wr, a_write, a_err, borrow;
   logic [31:0]   a_addr, a_wdata, off, mask;
   logic [3:0]    a_be;
   logic [AW-1:0] idx;
   // With zero wait the access happens on the accept edge, so it must use the live request
   always_comb begin
      acc     = state == IDLE && bus.req_valid && bus.req_ready;
      commit  = (acc && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
      a_write = state == IDLE ? bus.req_write : l_write;
      a_addr  = state == IDLE ? bus.req_addr  : l_addr;
      a_wdata = state == IDLE ? bus.req_wdata : l_wdata;
      a_be    = state == IDLE ? bus.req_be    : l_be;
      {borrow, off} = {1'b0, a_addr} - {1'b0, ADDR_BASE};
      a_err   = a_addr[1:0] != 2'b00 || borrow || off[31:2] >= 30'(DEPTH_WORDS);
      idx     = off[AW+1:2];
      wr      = commit && a_write && !a_err;
      mask    = {{8{a_be[3]}}, {8{a_be[2]}}, {8{a_be[1]}}, {8{a_be[0]}}};
   end
   for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_mem
      always_ff @(posedge clk)
         if (!reset) mem[w] <= '0;
         else if (wr && idx == AW'(w)) mem[w] <= (mem[w] & ~mask) | (a_wdata & mask);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.req_ready <= !acc;
               if (acc) begin
                  l_write <= bus.req_write;
                  l_addr  <= bus.req_addr;
                  l_wdata <= bus.req_wdata;
                  l_be    <= bus.req_be;
                  cnt     <= WL;
                  state   <= WAIT_CYCLES == 0 ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) state <= RESP;
            end
            default: if (bus.resp_ready) begin
               bus.resp_valid <= 1'b0;
               bus.resp_rdata <= '0;
               bus.resp_err   <= 1'b0;
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
         endcase
         if (commit) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= a_err;
            bus.resp_rdata <= a_err || a_write ? '0 : mem[idx];
         end
      end
   end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: randomized scoreboard bench for a 2-wait instance and a zero-wait instance
module tb_mips_dmem_responder;
   localparam int DEPTH = 256;
   localparam int W0 = 2;
   typedef struct {
      logic [31:0] rdata;
      logic        err;
      longint      t;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst0 = 1'b0, rst1 = 1'b0;
   mips_dmem_responder_if b0();
   mips_dmem_responder_if b1();
   mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .ADDR_BASE(32'h0)) dut0 (
      .clk(clk), .reset(rst0), .bus(b0.slave));
   mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut1 (
      .clk(clk), .reset(rst1), .bus(b1.slave));
   exp_t        q0[$], q1[$];
   logic [31:0] mm [2][DEPTH];
   int          checks = 0, errors = 0;
   int          rr_mode = 0;
   bit          done1 = 1'b0;
   logic        pv [2] = '{1'b0, 1'b0};
   logic        cl [2] = '{1'b0, 1'b0};
   logic [31:0] hrd [2];
   logic        he [2];
   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask
   // Reference: word-addressed memory, error if misaligned or beyond the last word
   function automatic exp_t model(int d, bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
      exp_t e;
      longint unsigned i = longint'(a) / 4;
      e.err   = (a % 4 != 0) || (i >= DEPTH);
      e.rdata = '0;
      e.t     = $time;
      if (!e.err) begin
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mm[d][int'(i)][8*b +: 8] = wd[8*b +: 8];
         end else e.rdata = mm[d][int'(i)];
      end
      return e;
   endfunction
   task automatic mon(int d, logic v, logic rr, logic qr, logic [31:0] rd, logic e, int w);
      exp_t x;
      if (cl[d]) begin
         chk($sformatf("clear_valid%0d", d), 32'(v), 32'd0);
         chk($sformatf("clear_rdata%0d", d), rd, 32'd0);
         chk($sformatf("clear_err%0d", d), 32'(e), 32'd0);
      end
      if (v && !pv[d]) begin
         if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp%0d: actual=response required=none", d);
         end else begin
            x = d == 0 ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata%0d", d), rd, x.rdata);
            chk($sformatf("err%0d", d), 32'(e), 32'(x.err));
            chk($sformatf("latency%0d", d), 32'($time - x.t), 32'(w * 10 + 5));
         end
         hrd[d] = rd;
         he[d]  = e;
      end else if (v) begin
         chk($sformatf("hold_rdata%0d", d), rd, hrd[d]);
         chk($sformatf("hold_err%0d", d), 32'(e), 32'(he[d]));
      end
      if (v) chk($sformatf("busy_ready%0d", d), 32'(qr), 32'd0);
      cl[d] = v && rr;
      pv[d] = v;
   endtask
   always @(negedge clk) begin
      if (!rst0) begin
         pv[0] = 1'b0;
         cl[0] = 1'b0;
      end else mon(0, b0.resp_valid, b0.resp_ready, b0.req_ready, b0.resp_rdata, b0.resp_err, W0);
      if (!rst1) begin
         pv[1] = 1'b0;
         cl[1] = 1'b0;
      end else mon(1, b1.resp_valid, b1.resp_ready, b1.req_ready, b1.resp_rdata, b1.resp_err, 0);
   end
   always @(posedge clk) begin
      #1;
      b0.resp_ready = rr_mode == 1 ? 1'b0 : rr_mode == 2 ? 1'b1 : $urandom_range(0, 3) != 0;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1);
   end
   task automatic send0(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
      int n = 0;
      @(negedge clk);
      b0.req_write = w;
      b0.req_addr  = a;
      b0.req_wdata = wd;
      b0.req_be    = be;
      b0.req_valid = 1'b1;
      while (!b0.req_ready) begin
         @(negedge clk);
         if (++n > 100) begin
            $display("FAIL accept_timeout0: actual=no_accept required=accept");
            $fatal(1);
         end
      end
      @(posedge clk);
      q0.push_back(model(0, w, a, wd, be));
      #1;
      b0.req_valid = 1'b0;
      b0.req_write = 1'($urandom);
      b0.req_addr  = $urandom;
      b0.req_wdata = $urandom;
      b0.req_be    = 4'($urandom);
   endtask
   task automatic reset0(int cycles);
      rst0 = 1'b0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(b0.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
      chk("rst_resp_rdata", b0.resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(b0.resp_err), 32'd0);
      q0.delete();
      for (int i = 0; i < DEPTH; i++) mm[0][i] = '0;
      @(posedge clk);
      #1 rst0 = 1'b1;
   endtask
   task automatic drain0();
      int n = 0;
      while (q0.size() != 0 || b0.resp_valid) begin
         @(negedge clk);
         if (++n > 500) begin
            $display("FAIL drain_timeout0: actual=%0d pending required=0", q0.size());
            $fatal(1);
         end
      end
      @(negedge clk);
   endtask
   initial begin
      int n;
      logic [31:0] a;
      b0.req_valid = 1'b0;
      b0.req_write = 1'b0;
      b0.req_addr  = '0;
      b0.req_wdata = '0;
      b0.req_be    = '0;
      reset0(2);
      send0(1, 32'h0, 32'h0000_000A, 4'b1111);
      send0(0, 32'h0, 32'h0, 4'b0000);
      send0(1, 32'h4, 32'hFFFF_FFFF, 4'b1111);
      send0(1, 32'h4, 32'h0000_0012, 4'b0001);
      send0(0, 32'h4, 32'h0, 4'b0000);
      send0(0, 32'h2, 32'h0, 4'b1111);
      send0(1, 32'h400, 32'hDEAD_BEEF, 4'b1111);
      send0(0, 32'h0, 32'h0, 4'b0000);
      drain0();
      rr_mode = 1;
      send0(0, 32'h4, 32'h0, 4'b0000);
      n = 0;
      while (!b0.resp_valid) begin
         @(negedge clk);
         if (++n > 50) begin
            $display("FAIL resp_timeout0: actual=no_valid required=valid");
            $fatal(1);
         end
      end
      repeat (3) @(negedge clk);
      rr_mode = 2;
      drain0();
      rr_mode = 0;
      for (int k = 0; k < 60; k++) begin
         n = $urandom_range(0, 9);
         a = n == 0 ? 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3)) :
             n == 1 ? 32'h400 + 32'(4 * $urandom_range(0, 1000)) :
                      32'(4 * $urandom_range(0, 15));
         send0(1'($urandom), a, $urandom, 4'($urandom));
      end
      drain0();
      send0(1, 32'h8, 32'h55AA_55AA, 4'b1111);
      send0(1, 32'h0, 32'h0000_1234, 4'b1111);
      drain0();
      send0(1, 32'h8, 32'h0000_0077, 4'b1111);
      reset0(1);
      send0(0, 32'h8, 32'h0, 4'b0000);
      send0(0, 32'h0, 32'h0, 4'b0000);
      drain0();
      n = 0;
      while (!done1) begin
         @(negedge clk);
         if (++n > 2000) begin
            $display("FAIL done_timeout1: actual=busy required=done");
            $fatal(1);
         end
      end
      chk("leftover0", 32'(q0.size()), 32'd0);
      chk("leftover1", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   // Zero-wait instance: request held valid continuously with response always taken
   initial begin
      longint last = 0;
      int n;
      logic [31:0] a;
      b1.req_valid  = 1'b0;
      b1.req_write  = 1'b0;
      b1.req_addr   = '0;
      b1.req_wdata  = '0;
      b1.req_be     = '0;
      b1.resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst1 = 1'b1;
      @(negedge clk);
      b1.req_valid = 1'b1;
      for (int k = 0; k < 30; k++) begin
         n = 0;
         a = k % 7 == 6 ? 32'(4 * $urandom_range(0, 7) + 2) : 32'(4 * $urandom_range(0, 7));
         b1.req_write = k < 8 ? 1'b1 : 1'($urandom);
         b1.req_addr  = a;
         b1.req_wdata = $urandom;
         b1.req_be    = 4'($urandom);
         while (!b1.req_ready) begin
            @(negedge clk);
            if (++n > 50) begin
               $display("FAIL accept_timeout1: actual=no_accept required=accept");
               $fatal(1);
            end
         end
         @(posedge clk);
         q1.push_back(model(1, b1.req_write, b1.req_addr, b1.req_wdata, b1.req_be));
         if (k > 0) chk("b2b_gap1", 32'($time - last), 32'd20);
         last = $time;
         @(negedge clk);
      end
      b1.req_valid = 1'b0;
      n = 0;
      while (q1.size() != 0 || b1.resp_valid) begin
         @(negedge clk);
         if (++n > 100) begin
            $display("FAIL drain_timeout1: actual=%0d pending required=0", q1.size());
            $fatal(1);
         end
      end
      @(negedge clk);
      done1 = 1'b1;
   end
endmodule
